// File: rtl/rat_remap_unit_pkg.sv
// Shared constants, state encoding and default geometry for the register alias tables.
package rat_remap_unit_pkg;

  localparam logic EnableValue = 1'b1;
  localparam logic AbleValue   = 1'b0;

  localparam int unsigned ARCH_REG_W     = 5;
  localparam int unsigned ArchRegsDef    = 32;
  localparam int unsigned PregWDef       = 6;
  localparam int unsigned RecovLanesDef  = 8;

  typedef enum logic {
    RAT_IDLE = 1'b0,
    RAT_COPY = 1'b1
  } ratState_t;

endpackage

// File: rtl/rat_remap_unit_table.sv
// Register alias table: identity at reset, 4 combinational reads, 2 prioritised writes
// (port 1 wins), and a masked bulk-load port. Entry 0 is hardwired to tag 0.
module rat_table
  import rat_remap_unit_pkg::*;
#(
  parameter int unsigned ARCH_REGS = ArchRegsDef,
  parameter int unsigned PREG_W    = PregWDef,
  localparam int unsigned AW       = $clog2(ARCH_REGS)
) (
  input  logic                              Clk,
  input  logic                              Rest,
  input  logic [AW-1:0]                     RdAddr0,
  input  logic [AW-1:0]                     RdAddr1,
  input  logic [AW-1:0]                     RdAddr2,
  input  logic [AW-1:0]                     RdAddr3,
  output logic [PREG_W-1:0]                 RdTag0,
  output logic [PREG_W-1:0]                 RdTag1,
  output logic [PREG_W-1:0]                 RdTag2,
  output logic [PREG_W-1:0]                 RdTag3,
  input  logic                              Wen0,
  input  logic [AW-1:0]                     WAddr0,
  input  logic [PREG_W-1:0]                 WTag0,
  input  logic                              Wen1,
  input  logic [AW-1:0]                     WAddr1,
  input  logic [PREG_W-1:0]                 WTag1,
  input  logic [ARCH_REGS-1:0]              BulkMask,
  input  logic [ARCH_REGS-1:0][PREG_W-1:0]  BulkData,
  output logic [ARCH_REGS-1:0][PREG_W-1:0]  Entries
);

  // Point writes take priority over the bulk port; entry 0 is never written.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) begin
        Entries[i] <= PREG_W'(i);
      end
    end else begin
      for (int i = 1; i < int'(ARCH_REGS); i++) begin
        if (Wen1 && (WAddr1 == AW'(i))) begin
          Entries[i] <= WTag1;
        end else if (Wen0 && (WAddr0 == AW'(i))) begin
          Entries[i] <= WTag0;
        end else if (BulkMask[i]) begin
          Entries[i] <= BulkData[i];
        end
      end
    end
  end

  assign RdTag0 = (RdAddr0 == '0) ? '0 : Entries[RdAddr0];
  assign RdTag1 = (RdAddr1 == '0) ? '0 : Entries[RdAddr1];
  assign RdTag2 = (RdAddr2 == '0) ? '0 : Entries[RdAddr2];
  assign RdTag3 = (RdAddr3 == '0) ? '0 : Entries[RdAddr3];

endmodule

// File: rtl/rat_remap_unit.sv
// Speculative/architectural RAT pair with a multi-cycle aRAT->sRAT recovery copy
// that stalls rename while in progress.
module rat_remap_unit
  import rat_remap_unit_pkg::*;
#(
  parameter int unsigned ARCH_REGS   = ArchRegsDef,
  parameter int unsigned PREG_W      = PregWDef,
  parameter int unsigned RECOV_LANES = RecovLanesDef,
  localparam int unsigned AW         = $clog2(ARCH_REGS)
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              aRATRemapping,
  input  logic [AW-1:0]     RdAddr0,
  input  logic [AW-1:0]     RdAddr1,
  input  logic [AW-1:0]     RdAddr2,
  input  logic [AW-1:0]     RdAddr3,
  output logic [PREG_W-1:0] RdTag0,
  output logic [PREG_W-1:0] RdTag1,
  output logic [PREG_W-1:0] RdTag2,
  output logic [PREG_W-1:0] RdTag3,
  input  logic              RnWen0,
  input  logic [AW-1:0]     RnAddr0,
  input  logic [PREG_W-1:0] RnTag0,
  input  logic              RnWen1,
  input  logic [AW-1:0]     RnAddr1,
  input  logic [PREG_W-1:0] RnTag1,
  input  logic              CmWen0,
  input  logic [AW-1:0]     CmAddr0,
  input  logic [PREG_W-1:0] CmTag0,
  input  logic              CmWen1,
  input  logic [AW-1:0]     CmAddr1,
  input  logic [PREG_W-1:0] CmTag1,
  output logic              RenameStall,
  output logic              RecovDone
);

  localparam int unsigned NumGroups = ARCH_REGS / RECOV_LANES;
  localparam int unsigned GrpW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;

  ratState_t                          stateQ, stateD;
  logic [GrpW-1:0]                    grpQ, grpD;
  logic                               recovDoneD;
  logic [ARCH_REGS-1:0][PREG_W-1:0]   aEntries;
  logic [ARCH_REGS-1:0]               sBulkMask;
  logic [ARCH_REGS-1:0][PREG_W-1:0]   sBulkData;
  logic                               sRnWen0, sRnWen1;

  logic [PREG_W-1:0]                  unusedATag0, unusedATag1, unusedATag2, unusedATag3;
  logic [ARCH_REGS-1:0][PREG_W-1:0]   unusedSEntries;

  assign RenameStall = aRATRemapping | (stateQ == RAT_COPY);
  assign sRnWen0     = RnWen0 & ~RenameStall;
  assign sRnWen1     = RnWen1 & ~RenameStall;

  // Copy the active group from aRAT; while stalled, commits also land in sRAT and win.
  always_comb begin
    sBulkMask = '0;
    sBulkData = '0;
    for (int i = 0; i < int'(ARCH_REGS); i++) begin
      sBulkData[i] = aEntries[i];
      if (CmWen0 && (CmAddr0 == AW'(i))) sBulkData[i] = CmTag0;
      if (CmWen1 && (CmAddr1 == AW'(i))) sBulkData[i] = CmTag1;
      sBulkMask[i] = ((stateQ == RAT_COPY) && (GrpW'(i / int'(RECOV_LANES)) == grpQ)) ||
                     (RenameStall && ((CmWen0 && (CmAddr0 == AW'(i))) ||
                                      (CmWen1 && (CmAddr1 == AW'(i)))));
    end
  end

  always_comb begin
    stateD     = stateQ;
    grpD       = grpQ;
    recovDoneD = AbleValue;
    case (stateQ)
      RAT_IDLE: begin
        if (aRATRemapping == EnableValue) begin
          stateD = RAT_COPY;
          grpD   = '0;
        end
      end
      RAT_COPY: begin
        if (aRATRemapping == EnableValue) begin
          grpD = '0;
        end else if (grpQ == GrpW'(NumGroups - 1)) begin
          stateD     = RAT_IDLE;
          grpD       = '0;
          recovDoneD = EnableValue;
        end else begin
          grpD = grpQ + GrpW'(1);
        end
      end
      default: stateD = RAT_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      stateQ    <= RAT_IDLE;
      grpQ      <= '0;
      RecovDone <= 1'b0;
    end else begin
      stateQ    <= stateD;
      grpQ      <= grpD;
      RecovDone <= recovDoneD;
    end
  end

  rat_table #(.ARCH_REGS(ARCH_REGS), .PREG_W(PREG_W)) sRat (
    .Clk      (Clk),
    .Rest     (Rest),
    .RdAddr0  (RdAddr0),
    .RdAddr1  (RdAddr1),
    .RdAddr2  (RdAddr2),
    .RdAddr3  (RdAddr3),
    .RdTag0   (RdTag0),
    .RdTag1   (RdTag1),
    .RdTag2   (RdTag2),
    .RdTag3   (RdTag3),
    .Wen0     (sRnWen0),
    .WAddr0   (RnAddr0),
    .WTag0    (RnTag0),
    .Wen1     (sRnWen1),
    .WAddr1   (RnAddr1),
    .WTag1    (RnTag1),
    .BulkMask (sBulkMask),
    .BulkData (sBulkData),
    .Entries  (unusedSEntries)
  );

  rat_table #(.ARCH_REGS(ARCH_REGS), .PREG_W(PREG_W)) aRat (
    .Clk      (Clk),
    .Rest     (Rest),
    .RdAddr0  ('0),
    .RdAddr1  ('0),
    .RdAddr2  ('0),
    .RdAddr3  ('0),
    .RdTag0   (unusedATag0),
    .RdTag1   (unusedATag1),
    .RdTag2   (unusedATag2),
    .RdTag3   (unusedATag3),
    .Wen0     (CmWen0),
    .WAddr0   (CmAddr0),
    .WTag0    (CmTag0),
    .Wen1     (CmWen1),
    .WAddr1   (CmAddr1),
    .WTag1    (CmTag1),
    .BulkMask ('0),
    .BulkData ('0),
    .Entries  (aEntries)
  );

endmodule
